// File: rtl/sseg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver.
// Shows a 32-bit word as hex with leading-zero blanking, dashes for the
// empty flag and a slow blink for the full flag. Display inputs are
// captured once per frame so a frame never mixes old and new data.
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8,
  parameter int BLINK_LOG2  = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        empty,
  input  logic        full,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [7:0] AN_OFF   = 8'hFF;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Hex nibble to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Index of the most significant nonzero nibble; 0 when the word is zero,
  // which keeps digit 0 lit so a zero value shows a single "0".
  function automatic logic [2:0] top_nibble(input logic [31:0] v);
    logic [2:0] hi;
    hi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'h0) begin
        hi = 3'(i);
      end else begin
        hi = hi;
      end
    end
    return hi;
  endfunction

  logic [CNT_W-1:0]      refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic [31:0]           shadow_value_q, shadow_value_d;
  logic                  shadow_empty_q, shadow_empty_d;
  logic                  shadow_full_q, shadow_full_d;
  logic [7:0]            an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  refresh_wrap_s;
  logic                  frame_end_s;
  logic [2:0]            top_idx_s;
  logic [3:0]            nibble_s;

  // Scan counters and frame-boundary capture of the display inputs.
  always_comb begin
    refresh_cnt_d  = refresh_cnt_q;
    digit_idx_d    = digit_idx_q;
    shadow_value_d = shadow_value_q;
    shadow_empty_d = shadow_empty_q;
    shadow_full_d  = shadow_full_q;
    blink_cnt_d    = blink_cnt_q + {{(BLINK_LOG2-1){1'b0}}, 1'b1};

    refresh_wrap_s = (refresh_cnt_q == CNT_LAST);
    frame_end_s    = refresh_wrap_s && (digit_idx_q == IDX_LAST);

    if (refresh_wrap_s) begin
      refresh_cnt_d = {CNT_W{1'b0}};
      if (digit_idx_q == IDX_LAST) begin
        digit_idx_d = {IDX_W{1'b0}};
      end else begin
        digit_idx_d = digit_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      refresh_cnt_d = refresh_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      digit_idx_d   = digit_idx_q;
    end

    if (frame_end_s) begin
      shadow_value_d = value;
      shadow_empty_d = empty;
      shadow_full_d  = full;
    end else begin
      shadow_value_d = shadow_value_q;
      shadow_empty_d = shadow_empty_q;
      shadow_full_d  = shadow_full_q;
    end
  end

  // Anode/segment pattern for the current slot, applying blink, dash and blanking in priority order.
  always_comb begin
    an_d      = AN_OFF;
    seg_d     = SEG_OFF;
    dp_d      = 1'b1;
    top_idx_s = top_nibble(shadow_value_q);
    nibble_s  = shadow_value_q[{digit_idx_q, 2'b00} +: 4];

    if (shadow_full_q && blink_cnt_q[BLINK_LOG2-1]) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else if (shadow_empty_q) begin
      an_d  = ~(8'h01 << digit_idx_q);
      seg_d = SEG_DASH;
    end else if (digit_idx_q > top_idx_s) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else begin
      an_d  = ~(8'h01 << digit_idx_q);
      seg_d = hex_to_seg(nibble_s);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q  <= {CNT_W{1'b0}};
      digit_idx_q    <= {IDX_W{1'b0}};
      blink_cnt_q    <= {BLINK_LOG2{1'b0}};
      shadow_value_q <= 32'h0000_0000;
      shadow_empty_q <= 1'b0;
      shadow_full_q  <= 1'b0;
      an_q           <= AN_OFF;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
    end else begin
      refresh_cnt_q  <= refresh_cnt_d;
      digit_idx_q    <= digit_idx_d;
      blink_cnt_q    <= blink_cnt_d;
      shadow_value_q <= shadow_value_d;
      shadow_empty_q <= shadow_empty_d;
      shadow_full_q  <= shadow_full_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (REFRESH_DIV=4, BLINK_LOG2=5).
// Every cycle is compared against a reference model that derives the scan
// position and blink phase arithmetically from the cycle count since reset.
module tb_sseg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLOG  = 5;
  localparam int FRAME = 8 * DIV;
  localparam int BPER  = 1 << BLOG;

  localparam logic [6:0] HEXT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [63:0] ONEHOT = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        empty;
  logic        full;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  sseg_scan_driver #(.REFRESH_DIV(DIV), .NUM_DIGITS(8), .BLINK_LOG2(BLOG)) dut (
    .clk(clk), .rst(rst), .value(value), .empty(empty), .full(full),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference state: cycles since reset release, and the frame-latched inputs.
  int          m = 0;
  logic [31:0] sh_v = 32'h0;
  logic        sh_e = 1'b0;
  logic        sh_f = 1'b0;

  typedef struct {
    logic [31:0]     v;
    logic            e;
    logic            f;
    logic [7:0][7:0] an;
    logic [7:0][6:0] sg;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m);
  endtask

  // What the display should show after an edge whose pre-edge position is mm.
  function automatic void model(input int mm, input logic [31:0] v, input logic e, input logic f,
                                output logic [7:0] ea, output logic [6:0] es);
    int d;
    int hi;
    bit dark_half;
    d = (mm / DIV) % 8;
    dark_half = ((mm % BPER) >= (BPER / 2));
    hi = 0;
    for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) hi = i;
    if (f && dark_half) begin
      ea = 8'hFF; es = 7'h7F;
    end else if (e) begin
      ea = ~(8'h01 << d); es = 7'h3F;
    end else if (d > hi) begin
      ea = 8'hFF; es = 7'h7F;
    end else begin
      ea = ~(8'h01 << d); es = HEXT[v[4*d +: 4]];
    end
  endfunction

  // One clock edge with a full model comparison afterwards.
  task automatic tick();
    logic [7:0] ea;
    logic [6:0] es;
    if (rst) begin
      ea = 8'hFF; es = 7'h7F;
    end else begin
      model(m, sh_v, sh_e, sh_f, ea, es);
      if ((m % FRAME) == FRAME - 1) begin
        sh_v = value; sh_e = empty; sh_f = full;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m = 0; sh_v = 32'h0; sh_e = 1'b0; sh_f = 1'b0;
    end else begin
      m++;
    end
    chk("model_an", 32'(an), 32'(ea));
    chk("model_seg", 32'(seg), 32'(es));
    chk("dp_off", 32'(dp), 32'd1);
  endtask

  task automatic set_vec(input int i, input logic [31:0] v, input logic e, input logic f,
                         input logic [63:0] a, input logic [55:0] s);
    tbl[i].v = v; tbl[i].e = e; tbl[i].f = f; tbl[i].an = a; tbl[i].sg = s;
  endtask

  initial begin
    set_vec(0, 32'h0000_00A5, 1'b0, 1'b0,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12});
    set_vec(1, 32'h8000_0000, 1'b0, 1'b0, ONEHOT,
            {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
    set_vec(2, 32'h1234_5678, 1'b1, 1'b0, ONEHOT,
            {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    set_vec(3, 32'h1234_5678, 1'b0, 1'b0, ONEHOT,
            {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});
    set_vec(4, 32'h0000_0000, 1'b0, 1'b0,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    set_vec(5, 32'h0000_0005, 1'b0, 1'b1,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    set_vec(6, 32'hDEAD_BEEF, 1'b1, 1'b1,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h3F, 7'h3F, 7'h3F});
    set_vec(7, 32'h0000_F000, 1'b0, 1'b1,
            {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
            {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40});

    // Reset held for three edges.
    rst = 1'b1; value = 32'h0; empty = 1'b0; full = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_an", 32'(an), 32'h0000_00FF);
      chk("reset_seg", 32'(seg), 32'h0000_007F);
    end
    rst = 1'b0;

    // First frame after release: a single "0" on digit 0, others dark.
    for (int k = 0; k < FRAME; k++) begin
      tick();
      chk("post_reset_an", 32'(an), (k < DIV) ? 32'h0000_00FE : 32'h0000_00FF);
      chk("post_reset_seg", 32'(seg), (k < DIV) ? 32'h0000_0040 : 32'h0000_007F);
    end

    // Table vectors: inputs scrambled every cycle of the checked frame, which must not tear.
    for (int i = 0; i < 8; i++) begin
      value = tbl[i].v; empty = tbl[i].e; full = tbl[i].f;
      do tick(); while ((m % FRAME) != 0);
      for (int k = 0; k < FRAME; k++) begin
        tick();
        chk("table_an", 32'(an), 32'(tbl[i].an[k / DIV]));
        chk("table_seg", 32'(seg), 32'(tbl[i].sg[k / DIV]));
        value = $urandom;
        empty = 1'($urandom_range(0, 1));
        full  = 1'($urandom_range(0, 1));
      end
    end

    // Reset asserted mid-frame: dark on the next edge, then scanning restarts at digit 0.
    value = 32'h0000_0777; empty = 1'b0; full = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_an", 32'(an), 32'h0000_00FF);
    chk("midrst_seg", 32'(seg), 32'h0000_007F);
    rst = 1'b0;
    for (int k = 0; k < DIV + 1; k++) begin
      tick();
      chk("restart_an", 32'(an), (k < DIV) ? 32'h0000_00FE : 32'h0000_00FF);
      chk("restart_seg", 32'(seg), (k < DIV) ? 32'h0000_0040 : 32'h0000_007F);
    end

    // Random stimulus with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      value = $urandom >> $urandom_range(0, 31);
      empty = ($urandom_range(0, 3) == 0);
      full  = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
